serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/half_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 147 ++++++++++++++
 tb/tb_serial_subtractor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// ----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor slice.
//   sub_state_t   : controller states (idle, shifting, result-valid)
//   DEFAULT_WIDTH : default operand/result width
// ----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_subtractor.sv
// ----------------------------------------------------------------------------
// half_subtractor
// One-bit half subtractor, X - Y. Two of these plus an OR form a full
// subtract cell.
// Ports:
//   X  : minuend bit
//   Y  : subtrahend bit
//   DF : difference bit (X ^ Y)
//   BR : borrow out (~X & Y)
// ----------------------------------------------------------------------------
module half_subtractor (
    input  logic X,
    input  logic Y,
    output logic DF,
    output logic BR
);

    assign DF = X ^ Y;
    assign BR = ~X & Y;

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor computing D = A - B one bit per clock, LSB first,
// using a single full-subtract cell and a borrow flop.
// Ports:
//   clk   : rising-edge system clock
//   rst_n : asynchronous active-low reset
//   start : request a subtraction (accepted when idle or in the done cycle)
//   A, B  : minuend / subtrahend, captured on the accepting edge
//   busy  : high while bits are being shifted
//   done  : one-cycle pulse, D/BOUT/V valid
//   D     : difference modulo 2^WIDTH (held until the next result)
//   BOUT  : final borrow, 1 iff A < B unsigned
//   V     : two's-complement overflow of the subtraction
// ----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             V
);

    sub_state_t       r_state;
    logic [WIDTH-1:0] r_aSr;
    logic [WIDTH-1:0] r_bSr;
    logic [WIDTH-1:0] r_dSr;
    logic             r_borrow;
    logic [CNT_W-1:0] r_count;
    logic             r_aMsb;
    logic             r_bMsb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_v;

    logic             w_df1;
    logic             w_br1;
    logic             w_diff;
    logic             w_br2;
    logic             w_bNext;
    logic [WIDTH-1:0] w_dNext;
    logic             w_lastBit;

    // Full subtract cell: first stage a0 - b0, second stage subtracts the
    // incoming borrow. The two partial borrows can never both be set.
    half_subtractor u_hsFirst (
        .X  (r_aSr[0]),
        .Y  (r_bSr[0]),
        .DF (w_df1),
        .BR (w_br1)
    );

    half_subtractor u_hsSecond (
        .X  (w_df1),
        .Y  (r_borrow),
        .DF (w_diff),
        .BR (w_br2)
    );

    assign w_bNext = w_br1 | w_br2;

    // New difference bit enters at the MSB, so after WIDTH shifts the
    // LSB-first bits have landed in their natural positions.
    assign w_dNext   = {w_diff, {(WIDTH-1){1'b0}}} | (r_dSr >> 1);
    assign w_lastBit = (r_count == CNT_W'(WIDTH - 1));

    assign busy = r_busy;
    assign done = r_done;
    assign D    = r_d;
    assign BOUT = r_bout;
    assign V    = r_v;

    // Controller and datapath. A start in the done cycle is accepted just
    // like one in idle, which gives back-to-back operation without a bubble.
    // Overflow uses the operand MSBs saved at acceptance because A/B may
    // change freely once the operation has started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_aSr    <= '0;
            r_bSr    <= '0;
            r_dSr    <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_aMsb   <= 1'b0;
            r_bMsb   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_d      <= '0;
            r_bout   <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_aSr    <= A;
                        r_bSr    <= B;
                        r_dSr    <= '0;
                        r_borrow <= 1'b0;
                        r_count  <= '0;
                        r_aMsb   <= A[WIDTH-1];
                        r_bMsb   <= B[WIDTH-1];
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_aSr    <= r_aSr >> 1;
                    r_bSr    <= r_bSr >> 1;
                    r_dSr    <= w_dNext;
                    r_borrow <= w_bNext;
                    r_count  <= r_count + CNT_W'(1);
                    if (w_lastBit) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_d     <= w_dNext;
                        r_bout  <= w_bNext;
                        r_v     <= (r_aMsb != r_bMsb) && (w_diff != r_aMsb);
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed and randomized checks of serial_subtractor against an arithmetic
// reference (integer subtraction and signed range check).
// ----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         BOUT;
    logic         V;

    int testCount = 0;
    int failCount = 0;
    int doneCount = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .BOUT  (BOUT),
        .V     (V)
    );

    always #5 clk = ~clk;

    // Counts done pulses as seen on each rising edge.
    always @(posedge clk) begin
        if (done) doneCount++;
    end

    // Arithmetic reference: plain integer subtraction, unsigned compare and
    // signed range test.
    function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] d, output logic bo,
                                     output logic v);
        int diff;
        int sa;
        int sb;
        int sd;
        diff = int'(a) - int'(b);
        d    = diff[W-1:0];
        bo   = (a < b);
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        sd   = sa - sb;
        v    = (sd > 127) || (sd < -128);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents operands with a one-cycle start pulse; returns at the falling
    // edge right after the accepting edge, with the inputs scrambled.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
    endtask

    // Waits (bounded) for done, counting falling edges and busy cycles.
    task automatic waitDone(output int cycles, output int busyCycles, output int overlap);
        cycles     = 0;
        busyCycles = busy ? 1 : 0;
        overlap    = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (busy) busyCycles++;
            if (busy && done) overlap = 1;
        end
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] expD;
        logic         expB;
        logic         expV;
        int           cyc;
        int           bc;
        int           ov;
        refModel(a, b, expD, expB, expV);
        applyStimulus(a, b);
        waitDone(cyc, bc, ov);
        checkOutput({tag, ".latency"}, cyc, W);
        checkOutput({tag, ".busyCycles"}, bc, W);
        checkOutput({tag, ".overlap"}, ov, 0);
        checkOutput({tag, ".D"}, D, expD);
        checkOutput({tag, ".BOUT"}, BOUT, expB);
        checkOutput({tag, ".V"}, V, expV);
        @(negedge clk);
        checkOutput({tag, ".donePulse"}, done, 1'b0);
    endtask

    initial begin
        int           cyc;
        int           bc;
        int           ov;
        int           dcBefore;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset.busy", busy, 1'b0);
        checkOutput("reset.done", done, 1'b0);
        checkOutput("reset.D", D, 8'h00);
        checkOutput("reset.BOUT", BOUT, 1'b0);
        checkOutput("reset.V", V, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed operand pairs, including borrow and overflow boundaries.
        runOp(8'h5A, 8'h3C, "op5A_3C");
        checkOutput("op5A_3C.Dconst", D, 8'h1E);
        runOp(8'h00, 8'h01, "op00_01");
        checkOutput("op00_01.Dconst", D, 8'hFF);
        checkOutput("op00_01.BOUTconst", BOUT, 1'b1);
        runOp(8'h80, 8'h01, "op80_01");
        checkOutput("op80_01.Dconst", D, 8'h7F);
        checkOutput("op80_01.Vconst", V, 1'b1);
        runOp(8'h7F, 8'hFF, "op7F_FF");
        runOp(8'h00, 8'h80, "op00_80");

        // A start during shifting is ignored and only one done results.
        dcBefore = doneCount;
        applyStimulus(8'h10, 8'h01);
        @(negedge clk);
        A     = 8'h77;
        B     = 8'h22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(cyc, bc, ov);
        checkOutput("ignore.doneSeen", done, 1'b1);
        checkOutput("ignore.D", D, 8'h0F);
        checkOutput("ignore.BOUT", BOUT, 1'b0);
        repeat (12) @(negedge clk);
        checkOutput("ignore.doneCount", doneCount - dcBefore, 1);
        checkOutput("ignore.idle", busy, 1'b0);

        // Back-to-back: start asserted during the done cycle.
        applyStimulus(8'h33, 8'h11);
        waitDone(cyc, bc, ov);
        checkOutput("b2b.first.done", done, 1'b1);
        checkOutput("b2b.first.D", D, 8'h22);
        A     = 8'hFF;
        B     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b.second.busy", busy, 1'b1);
        checkOutput("b2b.second.done", done, 1'b0);
        checkOutput("b2b.heldD", D, 8'h22);
        waitDone(cyc, bc, ov);
        checkOutput("b2b.second.latency", cyc, W);
        checkOutput("b2b.second.D", D, 8'h00);
        checkOutput("b2b.second.BOUT", BOUT, 1'b0);
        checkOutput("b2b.second.V", V, 1'b0);

        // Asynchronous reset mid-operation after a result with D and V set.
        runOp(8'h80, 8'h01, "preReset");
        applyStimulus(8'h5A, 8'h3C);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midReset.busy", busy, 1'b0);
        checkOutput("midReset.done", done, 1'b0);
        checkOutput("midReset.D", D, 8'h00);
        checkOutput("midReset.BOUT", BOUT, 1'b0);
        checkOutput("midReset.V", V, 1'b0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        dcBefore = doneCount;
        repeat (12) @(negedge clk);
        checkOutput("midReset.noDone", doneCount - dcBefore, 0);
        checkOutput("midReset.idle", busy, 1'b0);
        runOp(8'hC3, 8'h5A, "postReset");

        // Randomized sweep.
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            runOp(ra, rb, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
